// File: rtl/noc_link_arbiter_pkg.sv
// Noc_parameters: flit format, flit types and arbiter state shared by the link arbiter and its interface.
package Noc_parameters;
  localparam int VC_NUM = 2;
  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_t;
  typedef struct packed {
    flit_type_t flit_type;
    logic [VC_W-1:0] vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic logic is_head(flit_type_t t);
    return t == HEAD || t == HEADTAIL;
  endfunction
endpackage

// File: rtl/noc_link_arbiter_if.sv
// Noc_flit_interface: flit valid/ready link; vc_ready flows upstream alongside ready.
interface Noc_flit_interface;
  import Noc_parameters::*;
  logic valid;
  logic ready;
  flit_t flit;
  logic [VC_NUM-1:0] vc_ready;
  modport sender(output valid, flit, input ready, vc_ready);
  modport receiver(input valid, flit, output ready, vc_ready);
endinterface

// File: rtl/noc_link_arbiter_rr_arbiter_comb.sv
// rr_arbiter_comb: combinational round-robin pick, first request at or above ptr, else lowest request.
module rr_arbiter_comb #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);
  logic [PW-1:0] m_idx, u_idx;
  logic m_vld;
  always_comb begin
    m_idx = '0;
    u_idx = '0;
    m_vld = 1'b0;
    gnt_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        u_idx = PW'(i);
        gnt_vld = 1'b1;
      end
      if (req[i] && i >= int'(ptr)) begin
        m_idx = PW'(i);
        m_vld = 1'b1;
      end
    end
  end
  assign gnt_idx = m_vld ? m_idx : u_idx;
endmodule

// File: rtl/noc_link_arbiter.sv
// noc_link_arbiter: packet-level round-robin arbiter sharing one output link, locked per wormhole packet.
module noc_link_arbiter
  import Noc_parameters::*;
#(
  parameter int N_IN = 4,
  parameter int PTR_W = $clog2(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  Noc_flit_interface.receiver receiver_if [N_IN],
  Noc_flit_interface.sender   sender_if,
  output logic               lock_o,
  output logic [PTR_W-1:0]   owner_o,
  output logic               proto_err_o
);
  arb_state_t state;
  logic [PTR_W-1:0] rr_ptr, owner, gnt_idx, nxt;
  logic [N_IN-1:0] in_valid, elig, bad;
  logic gnt_vld, out_valid, acc_en, xfer;
  flit_t in_flit [N_IN];
  flit_t out_flit, win_flit;
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    logic head;
    assign in_valid[i] = receiver_if[i].valid;
    assign in_flit[i] = receiver_if[i].flit;
    assign head = is_head(in_flit[i].flit_type);
    assign receiver_if[i].vc_ready = sender_if.vc_ready;
    assign receiver_if[i].ready = rst_n && acc_en && gnt_vld && gnt_idx == PTR_W'(i);
    // offending flits are excluded from eligibility so they stall instead of being dropped
    assign elig[i] = in_valid[i] && sender_if.vc_ready[in_flit[i].vc_id] &&
                     (state == IDLE ? head : (owner == PTR_W'(i) && !head));
    assign bad[i] = in_valid[i] && (state == IDLE ? !head : (owner == PTR_W'(i) && head));
  end
  rr_arbiter_comb #(.N(N_IN)) u_rr (
    .req(elig),
    .ptr(rr_ptr),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );
  assign acc_en = !out_valid || sender_if.ready;
  assign xfer = acc_en && gnt_vld;
  assign win_flit = in_flit[gnt_idx];
  assign nxt = (gnt_idx == PTR_W'(N_IN - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign sender_if.valid = out_valid;
  assign sender_if.flit = out_flit;
  assign lock_o = state == LOCKED;
  assign owner_o = owner;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      out_valid <= 1'b0;
      out_flit <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (|bad) proto_err_o <= 1'b1;
      if (xfer) begin
        out_valid <= 1'b1;
        out_flit <= win_flit;
        if (win_flit.flit_type == HEAD) begin
          state <= LOCKED;
          owner <= gnt_idx;
        end
        // while locked the winner is always the owner, so nxt serves both packet-end cases
        if (win_flit.flit_type == TAIL || win_flit.flit_type == HEADTAIL) begin
          state <= IDLE;
          rr_ptr <= nxt;
        end
      end else if (acc_en) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
